// File: rtl/voice_scheduler.sv
// voice_scheduler: assigns song_reader notes to polyphonic voice slots,
// times hold and release in beats, and steals the nearest-to-finish voice.
module voice_scheduler #(
    parameter int NUM_VOICES     = 3,
    parameter int NOTE_WIDTH     = 6,
    parameter int DURATION_WIDTH = 6,
    parameter int RELEASE_BEATS  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             play,
    input  logic                             beat,
    input  logic                             new_note,
    input  logic [NOTE_WIDTH-1:0]            note,
    input  logic [DURATION_WIDTH-1:0]        duration,
    output logic                             note_done,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
    output logic [NUM_VOICES-1:0]            voice_active,
    output logic [NUM_VOICES-1:0]            voice_releasing,
    output logic [NUM_VOICES-1:0]            voice_load
);

    localparam int CW = (DURATION_WIDTH > 6) ? DURATION_WIDTH : 6;
    localparam int VW = (NUM_VOICES > 2) ? 2 : 1;
    localparam logic [CW-1:0] REL_CNT = CW'(RELEASE_BEATS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    typedef enum logic [1:0] {
        V_FREE    = 2'd0,
        V_HOLD    = 2'd1,
        V_RELEASE = 2'd2
    } vstate_t;

    fsm_t                  state_q, state_d;
    vstate_t               vstate_q [NUM_VOICES];
    vstate_t               vstate_d [NUM_VOICES];
    logic [CW-1:0]         vcount_q [NUM_VOICES];
    logic [CW-1:0]         vcount_d [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] vnote_q  [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] vnote_d  [NUM_VOICES];
    logic [CW-1:0]         rest_cnt_q, rest_cnt_d;
    logic [VW-1:0]         cur_q, cur_d;
    logic                  is_rest_q, is_rest_d;

    logic                  tick;
    logic                  accept;
    logic                  dur_zero;
    logic [VW-1:0]         alloc;
    logic [CW-1:0]         cur_count;
    logic                  hold_expire;

    assign tick     = beat && play;
    assign accept   = (state_q == S_IDLE) && new_note && play;
    assign dur_zero = (duration == '0);

    // Pick the target voice: lowest free slot, else the releasing voice closest to its end
    always_comb begin
        logic          found_free;
        logic          found_rel;
        logic [CW-1:0] best;
        alloc      = '0;
        found_free = 1'b0;
        found_rel  = 1'b0;
        best       = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found_free && vstate_q[i] == V_FREE) begin
                alloc      = VW'(i);
                found_free = 1'b1;
            end
        end
        if (!found_free) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (vstate_q[i] == V_RELEASE &&
                    (!found_rel || vcount_q[i] < best)) begin
                    alloc     = VW'(i);
                    best      = vcount_q[i];
                    found_rel = 1'b1;
                end
            end
        end
    end

    // Remaining hold beats of whatever the FSM is currently timing
    always_comb begin
        cur_count = rest_cnt_q;
        if (!is_rest_q) begin
            cur_count = vcount_q[cur_q];
        end
        hold_expire = (state_q == S_HOLD) && tick && (cur_count == CW'(1));
    end

    // Scheduler state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scheduler next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = dur_zero ? S_DONE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_expire) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scheduler outputs and voice status flattening
    always_comb begin
        note_done  = (state_q == S_DONE);
        voice_load = '0;
        if (accept && (note != '0)) begin
            voice_load[alloc] = 1'b1;
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_WIDTH +: NOTE_WIDTH] = vnote_q[i];
            voice_active[i]    = (vstate_q[i] != V_FREE);
            voice_releasing[i] = (vstate_q[i] == V_RELEASE);
        end
    end

    // Datapath next values: hold/release countdown, then new-note load overrides
    always_comb begin
        rest_cnt_d = rest_cnt_q;
        cur_d      = cur_q;
        is_rest_d  = is_rest_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            vstate_d[i] = vstate_q[i];
            vcount_d[i] = vcount_q[i];
            vnote_d[i]  = vnote_q[i];
            if (tick && vstate_q[i] == V_RELEASE) begin
                vcount_d[i] = vcount_q[i] - CW'(1);
                if (vcount_q[i] == CW'(1)) begin
                    vstate_d[i] = V_FREE;
                    vnote_d[i]  = '0;
                end
            end else if (tick && vstate_q[i] == V_HOLD &&
                         state_q == S_HOLD && !is_rest_q &&
                         cur_q == VW'(i)) begin
                if (vcount_q[i] == CW'(1)) begin
                    vstate_d[i] = V_RELEASE;
                    vcount_d[i] = REL_CNT;
                end else begin
                    vcount_d[i] = vcount_q[i] - CW'(1);
                end
            end
        end
        if (state_q == S_HOLD && is_rest_q && tick) begin
            rest_cnt_d = rest_cnt_q - CW'(1);
        end
        if (accept) begin
            if (note == '0) begin
                is_rest_d  = 1'b1;
                rest_cnt_d = CW'(duration);
            end else begin
                is_rest_d       = 1'b0;
                cur_d           = alloc;
                vnote_d[alloc]  = note;
                vstate_d[alloc] = dur_zero ? V_RELEASE : V_HOLD;
                vcount_d[alloc] = dur_zero ? REL_CNT : CW'(duration);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rest_cnt_q <= '0;
            cur_q      <= '0;
            is_rest_q  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate_q[i] <= V_FREE;
                vcount_q[i] <= '0;
                vnote_q[i]  <= '0;
            end
        end else begin
            rest_cnt_q <= rest_cnt_d;
            cur_q      <= cur_d;
            is_rest_q  <= is_rest_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate_q[i] <= vstate_d[i];
                vcount_q[i] <= vcount_d[i];
                vnote_q[i]  <= vnote_d[i];
            end
        end
    end

endmodule
